// File: rtl/sensor_qualifier_if.sv
// Sensor qualifier sample/result bundle: En and Raw in, qualified levels and
// transition pulses out. Clock and reset stay plain ports on the block.
interface sensor_qualifier_if #(
    parameter int NCH = 7
);
    logic           En;
    logic [NCH-1:0] Raw;
    logic [NCH-1:0] Q;
    logic [NCH-1:0] Rise;
    logic [NCH-1:0] Fall;
    logic           Chg;
    logic [NCH-1:0] Chat;

    modport master (output En, Raw, input Q, Rise, Fall, Chg, Chat);
    modport slave  (input En, Raw, output Q, Rise, Fall, Chg, Chat);
endinterface

// File: rtl/sensor_qualifier.sv
// Per-channel debounce qualifier for field-sensor levels with edge pulses.
// Optional per-channel chatter detection is compiled in by SENSOR_CHATTER_DETECT_EN.
module sensor_qualifier #(
    parameter int NCH    = 7,
    parameter int DB_LEN = 4,
    parameter int CW     = 3
) (
    input  logic             Ck,
    input  logic             Clr,
    sensor_qualifier_if.slave sq
);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [NCH-1:0] q_r;
    logic [NCH-1:0] rise_r;
    logic [NCH-1:0] fall_r;
    logic           chg_r;
    logic [CW-1:0]  cnt_r [NCH];

    logic [NCH-1:0] q_nxt_s;
    logic [NCH-1:0] rise_nxt_s;
    logic [NCH-1:0] fall_nxt_s;
    logic [CW-1:0]  cnt_nxt_s [NCH];

    // Debounce decision: a matching sample aborts, the DB_LEN-th mismatch qualifies.
    always_comb begin
        q_nxt_s    = q_r;
        rise_nxt_s = {NCH{1'b0}};
        fall_nxt_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sq.En) begin
                if (sq.Raw[i] == q_r[i]) begin
                    cnt_nxt_s[i] = CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    q_nxt_s[i]    = sq.Raw[i];
                    cnt_nxt_s[i]  = CNT_ZERO;
                    rise_nxt_s[i] = sq.Raw[i];
                    fall_nxt_s[i] = ~sq.Raw[i];
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // State and pulse registers; Clr wins over everything else.
    always_ff @(posedge Ck) begin
        if (Clr) begin
            q_r    <= {NCH{1'b0}};
            rise_r <= {NCH{1'b0}};
            fall_r <= {NCH{1'b0}};
            chg_r  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            q_r    <= q_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
            chg_r  <= |(rise_nxt_s | fall_nxt_s);
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign sq.Q    = q_r;
    assign sq.Rise = rise_r;
    assign sq.Fall = fall_r;
    assign sq.Chg  = chg_r;

`ifdef SENSOR_CHATTER_DETECT_EN
    logic [1:0]     abt_r     [NCH];
    logic [1:0]     abt_nxt_s [NCH];
    logic [NCH-1:0] chat_r;

    // Abort counting: only attempts that had made progress count as chatter.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            abt_nxt_s[i] = abt_r[i];
            if (rise_nxt_s[i] | fall_nxt_s[i]) begin
                abt_nxt_s[i] = 2'd0;
            end else if (sq.En && (sq.Raw[i] == q_r[i]) && (cnt_r[i] != CNT_ZERO)
                         && (abt_r[i] != 2'd3)) begin
                abt_nxt_s[i] = abt_r[i] + 2'd1;
            end else begin
                abt_nxt_s[i] = abt_r[i];
            end
        end
    end

    // Chatter registers; the flag mirrors a saturated abort counter.
    always_ff @(posedge Ck) begin
        if (Clr) begin
            chat_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                abt_r[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                abt_r[i]  <= abt_nxt_s[i];
                chat_r[i] <= (abt_nxt_s[i] == 2'd3);
            end
        end
    end

    assign sq.Chat = chat_r;
`else
    assign sq.Chat = {NCH{1'b0}};
`endif

endmodule

// File: tb/tb_sensor_qualifier.sv
// Self-checking bench for sensor_qualifier: directed scenarios then random
// stimulus, compared against a sample-history reference model.
module tb_sensor_qualifier;
    localparam int NCH    = 7;
    localparam int DB_LEN = 4;
    localparam int CW     = 3;

    logic Ck;
    logic Clr;
    int   n_checks;
    int   n_fail;

    sensor_qualifier_if #(.NCH(NCH)) sq ();

    sensor_qualifier #(.NCH(NCH), .DB_LEN(DB_LEN), .CW(CW)) dut (
        .Ck  (Ck),
        .Clr (Clr),
        .sq  (sq)
    );

    initial Ck = 1'b0;
    always #5 Ck = ~Ck;

    // Reference model: each channel remembers its enabled samples since the last
    // qualification; it flips once the newest DB_LEN samples all disagree with Q.
    logic [NCH-1:0] m_q;
    logic [NCH-1:0] m_rise;
    logic [NCH-1:0] m_fall;
    logic [NCH-1:0] m_chat;
    logic           m_chg;
    logic [31:0]    m_hist [NCH];
    int             m_len  [NCH];
    int             m_abt  [NCH];

    task automatic model_update(input logic clr, input logic en, input logic [NCH-1:0] raw);
        bit all_diff;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NCH; i++) begin
            if (clr) begin
                m_q[i]    = 1'b0;
                m_hist[i] = 32'd0;
                m_len[i]  = 0;
                m_abt[i]  = 0;
            end else if (en) begin
                if (raw[i] == m_q[i] && m_len[i] > 0 && m_hist[i][0] != m_q[i] && m_abt[i] < 3)
                    m_abt[i] = m_abt[i] + 1;
                m_hist[i] = {m_hist[i][30:0], raw[i]};
                if (m_len[i] < 32) m_len[i] = m_len[i] + 1;
                all_diff = (m_len[i] >= DB_LEN);
                for (int k = 0; k < DB_LEN; k++)
                    if (m_hist[i][k] == m_q[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_q[i]    = raw[i];
                    m_rise[i] = raw[i];
                    m_fall[i] = ~raw[i];
                    m_len[i]  = 0;
                    m_abt[i]  = 0;
                end
            end
`ifdef SENSOR_CHATTER_DETECT_EN
            m_chat[i] = (m_abt[i] == 3);
`else
            m_chat[i] = 1'b0;
`endif
        end
        m_chg = |(m_rise | m_fall);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic clr, input logic en, input logic [NCH-1:0] raw);
        Clr    = clr;
        sq.En  = en;
        sq.Raw = raw;
        @(posedge Ck);
        model_update(clr, en, raw);
        #1;
        chk("q",    32'(sq.Q),    32'(m_q));
        chk("rise", 32'(sq.Rise), 32'(m_rise));
        chk("fall", 32'(sq.Fall), 32'(m_fall));
        chk("chg",  32'(sq.Chg),  32'(m_chg));
        chk("chat", 32'(sq.Chat), 32'(m_chat));
    endtask

    initial begin
        logic [NCH-1:0] lvl;
        logic [7:0]     s5_seq;
        n_checks = 0;
        n_fail   = 0;
        Clr      = 1'b1;
        sq.En    = 1'b1;
        sq.Raw   = '0;

        // Scenario 1: all channels high through reset, qualify on 4th edge after release.
        step(1'b1, 1'b1, 7'h7F);
        step(1'b1, 1'b1, 7'h7F);
        chk("s1_q_in_clr", 32'(sq.Q), 32'h0);
        for (int n = 1; n <= 3; n++) step(1'b0, 1'b1, 7'h7F);
        chk("s1_q_before", 32'(sq.Q), 32'h0);
        step(1'b0, 1'b1, 7'h7F);
        chk("s1_q_after", 32'(sq.Q), 32'h7F);
        chk("s1_rise", 32'(sq.Rise), 32'h7F);
        chk("s1_chg", 32'(sq.Chg), 32'h1);
        step(1'b0, 1'b1, 7'h7F);
        chk("s1_rise_gone", 32'(sq.Rise), 32'h0);

        // Scenario 2: three-sample glitch never qualifies.
        step(1'b1, 1'b1, 7'h00);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 7'h01);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 7'h00);
        chk("s2_q", 32'(sq.Q), 32'h0);

        // Scenario 3: alternating enable, qualification on the 4th enabled edge.
        step(1'b1, 1'b1, 7'h00);
        for (int n = 1; n <= 7; n++) step(1'b0, (n % 2) == 1, 7'h04);
        chk("s3_q", 32'(sq.Q), 32'h04);
        chk("s3_rise", 32'(sq.Rise), 32'h04);
        step(1'b0, 1'b0, 7'h04);
        chk("s3_rise_en0", 32'(sq.Rise), 32'h0);

        // Scenario 4: bring channel 3 high, then four low samples give a fall.
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 7'h0C);
        chk("s4_q_hi", 32'(sq.Q), 32'h0C);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 7'h04);
        chk("s4_q_lo", 32'(sq.Q), 32'h04);
        chk("s4_fall", 32'(sq.Fall), 32'h08);
        chk("s4_rise", 32'(sq.Rise), 32'h0);

        // Scenario 5: chatter on channel 1, then a clean qualification.
        step(1'b1, 1'b1, 7'h00);
        s5_seq = 8'b0110_1011;
        for (int n = 0; n < 8; n++) step(1'b0, 1'b1, {5'b0, s5_seq[n], 1'b0});
`ifdef SENSOR_CHATTER_DETECT_EN
        chk("s5_chat_set", 32'(sq.Chat), 32'h02);
`else
        chk("s5_chat_set", 32'(sq.Chat), 32'h00);
`endif
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 7'h02);
        chk("s5_q", 32'(sq.Q), 32'h02);
        chk("s5_chat_clr", 32'(sq.Chat), 32'h00);

        // Scenario 6: Clr mid-count discards progress.
        step(1'b1, 1'b1, 7'h00);
        step(1'b0, 1'b1, 7'h10);
        step(1'b0, 1'b1, 7'h10);
        step(1'b1, 1'b1, 7'h10);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 7'h10);
        chk("s6_q_hold", 32'(sq.Q), 32'h00);
        step(1'b0, 1'b1, 7'h10);
        chk("s6_q_set", 32'(sq.Q), 32'h10);

        // Random phase: slowly toggling levels, mostly-enabled sampling, rare Clr.
        lvl = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 5) == 0) lvl[i] = ~lvl[i];
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sensor_qualifier.md
SENSOR_QUALIFIER -- requirements
Module: sensor_qualifier

Interface
REQ-001 The block SHALL have parameter NCH, default 7, giving the number of field-sensor channels; these are the I1..I7 level inputs to the init/operation FSMs.
REQ-002 The block SHALL have parameter DB_LEN, default 4, giving the number of consecutive enabled samples needed to accept a level change; legal range 1..7.
REQ-003 The block SHALL have parameter CW, default 3, giving the per-channel debounce counter width; 2^CW-1 >= DB_LEN.
REQ-004 Port Ck  input  1  system clock; every register updates on its rising edge.
REQ-005 Port Clr  input  1  reset, synchronous, active-high.
REQ-006 Port En  input  1  sample-enable tick; the block samples Raw only when En=1.
REQ-007 Port Raw  input  NCH  unfiltered sensor levels, asynchronous to nothing (already in the Ck domain).
REQ-008 Port Q  output  NCH  qualified sensor levels, registered, feeding the downstream FSMs.
REQ-009 Port Rise  output  NCH  one-cycle pulse per channel on a qualified 0->1 transition.
REQ-010 Port Fall  output  NCH  one-cycle pulse per channel on a qualified 1->0 transition.
REQ-011 Port Chg  output  1  OR-reduction of Rise|Fall, registered in the same cycle as Rise/Fall.
REQ-012 Port Chat  output  NCH  per-channel chatter flag (see Configuration).

Function
REQ-013 Each channel SHALL hold state {Q[i], cnt[i]}; all channels SHALL be independent.
REQ-014 With En=1 and Raw[i]==Q[i], cnt[i] SHALL load 0.
REQ-015 With En=1 and Raw[i]!=Q[i] and cnt[i]+1<DB_LEN, cnt[i] SHALL increment by 1.
REQ-016 With En=1 and Raw[i]!=Q[i] and cnt[i]+1==DB_LEN, Q[i] SHALL load Raw[i] and cnt[i] SHALL load 0 on that edge.
REQ-017 On that same edge, Rise[i] (new Q=1) or Fall[i] (new Q=0) SHALL be set, so each pulse is visible in the first cycle Q[i] shows its new value.
REQ-018 Rise/Fall/Chg SHALL be 0 in every cycle that does not follow a qualifying edge; none SHALL last more than one cycle.
REQ-019 With En=0, Q and cnt SHALL hold, and Rise/Fall/Chg SHALL be 0 on the next edge.
REQ-020 Latency SHALL be exactly DB_LEN enabled samples from the first mismatching sample; with DB_LEN=1, Q[i] SHALL follow Raw[i] one edge after each enabled sample.
REQ-021 Any enabled sample matching Q[i] before qualification SHALL abort the attempt, so a glitch shorter than DB_LEN samples never reaches Q.
REQ-022 cnt[i] SHALL never exceed DB_LEN-1, and no counter wrap-around SHALL occur.

Reset
REQ-023 Clr=1 SHALL on the next edge force Q=0, cnt=0, Rise=0, Fall=0, Chg=0, Chat=0, with priority over En and Raw.
REQ-024 Clr asserted mid-count SHALL discard partial progress, so a full DB_LEN enabled samples are needed after Clr deasserts.
REQ-025 No output SHALL pulse on the edge on which Clr is sampled high, nor on the first edge after release unless REQ-016 is met.

Configuration
REQ-026 Macro SENSOR_CHATTER_DETECT_EN SHALL compile in per-channel chatter detection.
REQ-027 When the macro is defined, each channel SHALL keep a 2-bit saturating abort counter, incremented when REQ-021 aborts an attempt with cnt[i]!=0.
REQ-028 When the macro is defined, Chat[i] SHALL be set when the abort counter reaches 3, and the abort counter and Chat[i] SHALL clear on a qualification of channel i or on Clr.
REQ-029 When the macro is undefined, Chat SHALL be tied to 0, the port SHALL remain present, and no abort counters SHALL exist.

Verification
All scenarios use defaults (NCH=7, DB_LEN=4) with En=1 unless stated.
REQ-030 Scenario 1: Raw=7'h7F during Clr=1 for 2 cycles, then held -> Q=0 through Clr; Q=7'h7F on the 4th edge after release; Rise=7'h7F and Chg=1 for exactly that one cycle.
REQ-031 Scenario 2: Raw[0]=1 for 3 samples, then 0 -> Q[0] stays 0; Rise=0 and Chg=0 throughout.
REQ-032 Scenario 3: En toggling 1,0,1,0..., Raw[2]=1 -> Q[2] rises on the 4th En=1 edge (cycle 7); Rise[2] is never high while En=0.
REQ-033 Scenario 4: Q[3]=1, then Raw[3]=0 for 4 samples -> Q[3]=0 and Fall[3]=1 for one cycle; Rise[3]=0.
REQ-034 Scenario 5: Raw[1] = 1,1,0,1,0,1,1,0 -> macro on: Chat[1]=1 after the third abort, cleared by a later 4-sample qualification; macro off: Chat=0 always.
REQ-035 Scenario 6: Raw[4]=1 for 2 samples, Clr=1 for 1 cycle, Raw[4]=1 for 3 more samples -> Q[4]=0; Q[4]=1 only on the 4th post-Clr sample.
